fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of write data words.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum consecutive writes per grant; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req0  input  1  requester 0 has a word to write; held until acked.
REQ-006 SHALL have port data0  input  DATA_WIDTH  requester 0 word; stable while req0=1 and ack0=0.
REQ-007 SHALL have port ack0  output  1  requester 0 word written this cycle.
REQ-008 SHALL have port req1  input  1  requester 1 has a word to write.
REQ-009 SHALL have port data1  input  DATA_WIDTH  requester 1 word.
REQ-010 SHALL have port ack1  output  1  requester 1 word written this cycle.
REQ-011 SHALL have port fifo_full  input  1  downstream FIFO full flag.
REQ-012 SHALL have port wr  output  1  FIFO write strobe.
REQ-013 SHALL have port w_data  output  DATA_WIDTH  FIFO write data.
REQ-014 SHALL have port grant  output  2  one-hot current owner (01=req0, 10=req1, 00=none).

Function
REQ-015 SHALL implement FSM states IDLE, OWN0, OWN1; grant = 00/01/10 respectively, driven from state.
REQ-016 SHALL hold register last (owner of most recent grant) and burst_cnt (0..MAX_BURST).
REQ-017 IDLE: req0 & req1 -> OWN of requester != last; only one requesting -> OWN of that one; none -> stay IDLE.
REQ-018 SHALL perform no write in IDLE; arbitration latency is exactly 1 cycle from req to first possible ack.
REQ-019 On entry to OWNx, SHALL load last=x and burst_cnt=0.
REQ-020 In OWNx, when reqx=1 and fifo_full=0: wr=1, w_data=datax, ackx=1 in the same cycle (combinational), burst_cnt increments.
REQ-021 In OWNx, when fifo_full=1: wr=0, ackx=0, burst_cnt unchanged, state held (full never forces yield).
REQ-022 OWNx -> IDLE when reqx=0 (no write that cycle).
REQ-023 OWNx -> IDLE after the write that brings burst_cnt to MAX_BURST, regardless of other requester.
REQ-024 SHALL never assert wr when fifo_full=1; SHALL never assert ack0 and ack1 together; ack for non-owner always 0.
REQ-025 wr SHALL equal ack0|ack1 every cycle; w_data SHALL be 0 when wr=0.
REQ-026 Simultaneous fifo_full deassert and reqx deassert in OWNx: no write, transition to IDLE.

Reset
REQ-027 On reset=1, SHALL immediately (asynchronously) set state=IDLE, last=1, burst_cnt=0; outputs wr=0, ack0=0, ack1=0, w_data=0, grant=00.
REQ-028 Reset mid-burst SHALL abort the grant; no wr/ack during reset; first post-reset tie goes to req0.
REQ-029 Requesters SHALL keep req asserted across reset; word not acked before reset is re-arbitrated afterwards.

Verification
REQ-030 Single requester: req0=1 for 3 words (A5,3C,7E), fifo_full=0 -> grant=01 cycle 1, wr/ack0 cycles 1-3 with w_data A5,3C,7E, IDLE after req0 drops.
REQ-031 Tie after reset: req0=req1=1 continuously, MAX_BURST=4 -> 4 writes from req0, 1 IDLE cycle, 4 writes from req1, alternating indefinitely.
REQ-032 Full stall: OWN0 mid-burst, fifo_full=1 for 5 cycles -> wr=0, ack0=0, grant stays 01, burst_cnt frozen; resumes writes when full drops.
REQ-033 Early release: OWN1 after 2 writes, req1=0 while req0=1 -> IDLE next cycle, then OWN0 (req0 wins, last=1).
REQ-034 Reset mid-burst: assert reset during OWN1 write cycle -> wr, ack1, grant drop to 0 same cycle; after release with both requesting, grant=01.
REQ-035 Invariants checked every cycle by assertion: wr=ack0|ack1, !(wr & fifo_full), !(ack0 & ack1), grant one-hot or zero.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Two-requester write arbiter for a downstream FIFO.
// Round-robin on ties, with bursts of at most MAX_BURST words per grant.
module fifo_wr_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ack1,
    input  logic                  fifo_full,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    localparam logic [3:0] BURST_END = 4'(MAX_BURST);

    state_t     state;
    state_t     state_nxt;
    logic       last;
    logic       last_nxt;
    logic [3:0] burst_cnt;
    logic [3:0] cnt_nxt;
    logic [3:0] cnt_inc;

    assign cnt_inc = burst_cnt + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = burst_cnt;
        ack0      = 1'b0;
        ack1      = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = 4'd0;
                // On a tie, the requester that did not own the last grant wins
                if (req0 && req1) begin
                    state_nxt = last ? OWN0 : OWN1;
                    last_nxt  = ~last;
                end else if (req0) begin
                    state_nxt = OWN0;
                    last_nxt  = 1'b0;
                end else if (req1) begin
                    state_nxt = OWN1;
                    last_nxt  = 1'b1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_nxt = IDLE;
                end else if (!fifo_full) begin
                    ack0    = 1'b1;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == BURST_END)
                        state_nxt = IDLE;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_nxt = IDLE;
                end else if (!fifo_full) begin
                    ack1    = 1'b1;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == BURST_END)
                        state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign wr    = ack0 | ack1;
    assign grant = {state == OWN1, state == OWN0};

    always_comb begin
        w_data = '0;
        if (ack0)
            w_data = data0;
        else if (ack1)
            w_data = data1;
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scenario bench for fifo_wr_arb: requester agents feed word queues,
// expected writes are queued in order and retired by a negedge monitor.
module tb_fifo_wr_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic       ack0;
    logic       req1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       ack1;
    logic       fifo_full;
    logic       wr;
    logic [7:0] w_data;
    logic [1:0] grant;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] w0q[$];
    logic [7:0] w1q[$];
    logic [8:0] exp_q[$];
    logic       en0;
    logic       en1;
    logic       t0;
    logic       t1;

    fifo_wr_arb #(.DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk),
        .reset(reset),
        .req0(req0),
        .data0(data0),
        .ack0(ack0),
        .req1(req1),
        .data1(data1),
        .ack1(ack1),
        .fifo_full(fifo_full),
        .wr(wr),
        .w_data(w_data),
        .grant(grant)
    );

    always #5 clk = ~clk;

    // Requester agents: hold the head word until it is acked
    always begin
        @(negedge clk);
        t0 = ack0;
        t1 = ack1;
        @(posedge clk);
        #2;
        if (t0 && w0q.size() > 0) void'(w0q.pop_front());
        if (t1 && w1q.size() > 0) void'(w1q.pop_front());
        req0  = en0 && (w0q.size() > 0);
        data0 = req0 ? w0q[0] : 8'h00;
        req1  = en1 && (w1q.size() > 0);
        data1 = req1 ? w1q[0] : 8'h00;
    end

    // Scoreboard retirement and per-cycle invariants
    always @(negedge clk) begin
        logic [8:0] e;
        vectors++;
        if (wr !== (ack0 | ack1)) begin
            miscompares++;
            $display("FAIL inv_wr: wr=%b ack0|ack1=%b", wr, ack0 | ack1);
        end
        vectors++;
        if (wr && fifo_full) begin
            miscompares++;
            $display("FAIL inv_full: wr=1 while fifo_full=1");
        end
        vectors++;
        if (ack0 && ack1) begin
            miscompares++;
            $display("FAIL inv_acks: ack0=1 and ack1=1");
        end
        vectors++;
        if (grant === 2'b11) begin
            miscompares++;
            $display("FAIL inv_grant: got %b want one-hot or 00", grant);
        end
        vectors++;
        if (wr) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_extra: unexpected write src=%b data=%h",
                         ack1, w_data);
            end else begin
                e = exp_q.pop_front();
                if ({ack1, w_data} !== e) begin
                    miscompares++;
                    $display("FAIL sb_word: got src=%b data=%h want src=%b data=%h",
                             ack1, w_data, e[8], e[7:0]);
                end
            end
        end else if (w_data !== 8'h00) begin
            miscompares++;
            $display("FAIL w_data_idle: got %h want 00", w_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        fifo_full = 1'b0;
        en0       = 1'b1;
        en1       = 1'b1;
        tick();
        tick();
        vectors++;
        if ({wr, ack0, ack1} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_strobes: got %b want 000", {wr, ack0, ack1});
        end
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_grant: got %b want 00", grant);
        end
        vectors++;
        if (w_data !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_wdata: got %h want 00", w_data);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_grant: got %b want 00", grant);
        end
    endtask

    task automatic test_single();
        logic [7:0] words[3] = '{8'hA5, 8'h3C, 8'h7E};
        foreach (words[i]) begin
            w0q.push_back(words[i]);
            exp_q.push_back({1'b0, words[i]});
        end
        tick();
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("FAIL single_grant: got %b want 01", grant);
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_drain: got %0d left want 0", exp_q.size());
        end
        tick();
        tick();
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("FAIL single_idle: got %b want 00", grant);
        end
    endtask

    task automatic test_tie();
        logic [1:0] seq[10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w0q.push_back(8'(8'h10 + i));
            w1q.push_back(8'(8'h20 + i));
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'(8'h10 + 4 * b + i)});
            for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'(8'h20 + 4 * b + i)});
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (grant !== seq[i]) begin
                miscompares++;
                $display("FAIL tie_grant[%0d]: got %b want %b", i, grant, seq[i]);
            end
        end
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL tie_drain: got %0d left want 0", exp_q.size());
        end
        repeat (3) tick();
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < 4; i++) begin
            w0q.push_back(8'(8'hB0 + i));
            exp_q.push_back({1'b0, 8'(8'hB0 + i)});
        end
        for (int i = 0; i < 10 && grant !== 2'b01; i++) tick();
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("FAIL stall_start: got %b want 01", grant);
        end
        tick();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            vectors++;
            if ({wr, ack0, grant} !== 4'b0001) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got wr=%b ack0=%b grant=%b want 0 0 01",
                         i, wr, ack0, grant);
            end
            tick();
        end
        fifo_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            vectors++;
            if ({wr, grant} !== 3'b101) begin
                miscompares++;
                $display("FAIL stall_resume[%0d]: got wr=%b grant=%b want 1 01",
                         i, wr, grant);
            end
            tick();
        end
        vectors++;
        if (grant !== 2'b00 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_end: got grant=%b left=%0d want 00 0",
                     grant, exp_q.size());
        end
        repeat (2) tick();
    endtask

    task automatic test_early_release();
        en0 = 1'b0;
        w0q.push_back(8'hD0);
        for (int i = 0; i < 4; i++) w1q.push_back(8'(8'hC0 + i));
        exp_q.push_back({1'b1, 8'hC0});
        exp_q.push_back({1'b1, 8'hC1});
        exp_q.push_back({1'b0, 8'hD0});
        for (int i = 0; i < 10 && grant !== 2'b10; i++) tick();
        vectors++;
        if (grant !== 2'b10) begin
            miscompares++;
            $display("FAIL early_start: got %b want 10", grant);
        end
        tick();
        tick();
        en1 = 1'b0;
        en0 = 1'b1;
        tick();
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("FAIL early_idle: got %b want 00", grant);
        end
        tick();
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("FAIL early_own0: got %b want 01", grant);
        end
        tick();
        w1q.delete();
        en1 = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL early_drain: got %0d left want 0", exp_q.size());
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_burst();
        en0 = 1'b0;
        for (int i = 0; i < 4; i++) w1q.push_back(8'(8'hE0 + i));
        w0q.push_back(8'hF0);
        w0q.push_back(8'hF1);
        exp_q.push_back({1'b1, 8'hE0});
        exp_q.push_back({1'b0, 8'hF0});
        exp_q.push_back({1'b0, 8'hF1});
        for (int i = 1; i < 4; i++) exp_q.push_back({1'b1, 8'(8'hE0 + i)});
        for (int i = 0; i < 10 && grant !== 2'b10; i++) tick();
        vectors++;
        if (grant !== 2'b10) begin
            miscompares++;
            $display("FAIL rmid_start: got %b want 10", grant);
        end
        tick();
        reset = 1'b1;
        en0   = 1'b1;
        #1;
        vectors++;
        if ({wr, ack1, grant} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rmid_abort: got wr=%b ack1=%b grant=%b want 0 0 00",
                     wr, ack1, grant);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("FAIL rmid_tie: got %b want 01", grant);
        end
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rmid_drain: got %0d left want 0", exp_q.size());
        end
        repeat (3) tick();
    endtask

    initial begin
        reset     = 1'b1;
        fifo_full = 1'b0;
        en0       = 1'b1;
        en1       = 1'b1;
        test_reset();
        test_single();
        test_tie();
        test_full_stall();
        test_early_release();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
